// File: rtl/llc_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : llc_mem_responder_pkg
// Description : Shared cache constants and the responder FSM state encoding.
//               LINE_ADDR_BITS  - width of a cache-line address
//               BITS_PER_LINE   - width of one cache line
//               LAT_BITS        - width of the read-latency down-counter
// Revision    : 1.0 - initial release
// ============================================================================
package llc_mem_responder_pkg;

  localparam int LINE_ADDR_BITS = 26;
  localparam int BITS_PER_LINE  = 128;
  localparam int LAT_BITS       = 8;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/llc_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : llc_mem_responder_if
// Description : LLC <-> memory request/response bundle.
//               Request : req_valid/req_ready handshake, hwrite, hsize,
//                         hprot, line address, write line.
//               Response: rsp_valid/rsp_ready handshake, read line.
//               master = LLC side, slave = memory responder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface llc_mem_responder_if;
  import llc_mem_responder_pkg::*;

  logic                      llc_mem_req_valid;
  logic                      llc_mem_req_ready;
  logic                      llc_mem_req_hwrite;
  logic [2:0]                llc_mem_req_hsize;
  logic [1:0]                llc_mem_req_hprot;
  logic [LINE_ADDR_BITS-1:0] llc_mem_req_addr;
  logic [BITS_PER_LINE-1:0]  llc_mem_req_line;
  logic                      llc_mem_rsp_valid;
  logic                      llc_mem_rsp_ready;
  logic [BITS_PER_LINE-1:0]  llc_mem_rsp_line;

  modport master (
    output llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_hsize,
           llc_mem_req_hprot, llc_mem_req_addr, llc_mem_req_line,
           llc_mem_rsp_ready,
    input  llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line
  );

  modport slave (
    input  llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_hsize,
           llc_mem_req_hprot, llc_mem_req_addr, llc_mem_req_line,
           llc_mem_rsp_ready,
    output llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line
  );

endinterface
`default_nettype wire

// File: rtl/llc_mem_store.sv
`default_nettype none
// ============================================================================
// Module      : llc_mem_store
// Description : Backing store, one synchronous write port and one
//               combinational read port. Contents are not reset; the
//               responder clears them by sweeping every entry after reset.
//   clk   - write clock
//   we    - write enable
//   waddr - write index
//   wdata - write line
//   raddr - read index
//   rdata - read line (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module llc_mem_store #(
  parameter  int DEPTH = 256,
  parameter  int WIDTH = 128,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/llc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : llc_mem_responder
// Description : Fixed-latency memory model answering LLC line requests.
//               After reset the store is zeroed one line per cycle (INIT),
//               then writes are absorbed one per cycle and a read returns
//               its line RD_LATENCY+1 cycles after acceptance.
//   clk      - sole clock, rising edge
//   rst      - asynchronous active-low reset
//   bus      - llc_mem_responder_if.slave request/response bundle
//   rd_count - read handshakes, saturating   (LLC_MEM_STATS_EN only)
//   wr_count - write handshakes, saturating  (LLC_MEM_STATS_EN only)
// Optional   : define LLC_MEM_STATS_EN to add the rd_count/wr_count outputs.
// Revision   : 1.0 - initial release
// ============================================================================
module llc_mem_responder
  import llc_mem_responder_pkg::*;
#(
  parameter int MEM_LINES  = 256,
  parameter int RD_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  llc_mem_responder_if.slave bus
`ifdef LLC_MEM_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam int IDX_W = $clog2(MEM_LINES);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         init_idx_q, init_idx_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [LAT_BITS-1:0]      cnt_q, cnt_d;
  logic [BITS_PER_LINE-1:0] rsp_line_q, rsp_line_d;

  logic                     req_ready;
  logic                     req_hs;
  logic                     rd_hs;
  logic                     wr_hs;
  logic [IDX_W-1:0]         req_idx;

  logic                     st_we;
  logic [IDX_W-1:0]         st_waddr;
  logic [BITS_PER_LINE-1:0] st_wdata;
  logic [IDX_W-1:0]         st_raddr;
  logic [BITS_PER_LINE-1:0] st_rdata;

  // Size, protection and the aliased upper address bits carry no meaning here.
  logic unused_req_bits;
  assign unused_req_bits = ^{bus.llc_mem_req_hsize, bus.llc_mem_req_hprot,
                             bus.llc_mem_req_addr};

  assign req_ready = (state_q == ST_IDLE);
  assign req_hs    = bus.llc_mem_req_valid & req_ready;
  assign wr_hs     = req_hs &  bus.llc_mem_req_hwrite;
  assign rd_hs     = req_hs & ~bus.llc_mem_req_hwrite;
  assign req_idx   = bus.llc_mem_req_addr[IDX_W-1:0];

  // INIT owns the write port for the zeroing sweep; afterwards only write
  // handshakes use it. Reads index the live request in IDLE (zero-latency
  // case) and the latched index otherwise.
  always_comb begin
    st_we    = 1'b0;
    st_waddr = req_idx;
    st_wdata = bus.llc_mem_req_line;
    if (state_q == ST_INIT) begin
      st_we    = 1'b1;
      st_waddr = init_idx_q;
      st_wdata = '0;
    end else if (wr_hs) begin
      st_we    = 1'b1;
    end
  end

  assign st_raddr = (state_q == ST_IDLE) ? req_idx : idx_q;

  llc_mem_store #(
    .DEPTH (MEM_LINES),
    .WIDTH (BITS_PER_LINE)
  ) u_store (
    .clk   (clk),
    .we    (st_we),
    .waddr (st_waddr),
    .wdata (st_wdata),
    .raddr (st_raddr),
    .rdata (st_rdata)
  );

  // Next-state logic. The response line is captured on entry to RESP so it
  // stays stable however long the LLC stalls.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rsp_line_d = rsp_line_q;
    unique case (state_q)
      ST_INIT: begin
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == IDX_W'(MEM_LINES - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (rd_hs) begin
          idx_d = req_idx;
          cnt_d = LAT_BITS'(RD_LATENCY);
          if (RD_LATENCY == 0) begin
            state_d    = ST_RESP;
            rsp_line_d = st_rdata;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Counter reaches zero on this edge: that closes the last WAIT cycle.
        if (cnt_q <= LAT_BITS'(1)) begin
          state_d    = ST_RESP;
          rsp_line_d = st_rdata;
        end
      end
      ST_RESP: begin
        if (bus.llc_mem_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rsp_line_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rsp_line_q <= rsp_line_d;
    end
  end

  assign bus.llc_mem_req_ready = req_ready;
  assign bus.llc_mem_rsp_valid = (state_q == ST_RESP);
  assign bus.llc_mem_rsp_line  = rsp_line_q;

`ifdef LLC_MEM_STATS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (rd_hs && (rd_count_q != '1)) begin
      rd_count_d = rd_count_q + 32'd1;
    end
    if (wr_hs && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_llc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_llc_mem_responder
// Description : Directed self-checking bench for llc_mem_responder
//               (MEM_LINES=256, RD_LATENCY=LAT). Define LLC_MEM_STATS_EN to
//               also exercise the read/write counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llc_mem_responder;
  import llc_mem_responder_pkg::*;

  localparam int LAT      = 4;
  localparam int INIT_CYC = 256;
  localparam int NV       = 12;

  typedef struct {
    logic                      wr;
    logic [LINE_ADDR_BITS-1:0] addr;
    logic [BITS_PER_LINE-1:0]  data;   // write data, or expected read data
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  llc_mem_responder_if bus ();

`ifdef LLC_MEM_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  llc_mem_responder #(
    .MEM_LINES  (256),
    .RD_LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LLC_MEM_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_rd   = 0;
  int   exp_wr   = 0;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [BITS_PER_LINE-1:0] act,
                     input logic [BITS_PER_LINE-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.llc_mem_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_timeout", bus.llc_mem_req_ready, 1);
  endtask

  // Called at a negedge right after reset release.
  task automatic wait_init(output int n, output logic saw_valid);
    n = 0;
    saw_valid = 1'b0;
    while (!bus.llc_mem_req_ready && n < 1000) begin
      @(negedge clk);
      n++;
      if (bus.llc_mem_rsp_valid) saw_valid = 1'b1;
    end
  endtask

  task automatic do_write(input logic [LINE_ADDR_BITS-1:0] addr,
                          input logic [BITS_PER_LINE-1:0] data);
    bus.llc_mem_req_valid  = 1'b1;
    bus.llc_mem_req_hwrite = 1'b1;
    bus.llc_mem_req_addr   = addr;
    bus.llc_mem_req_line   = data;
    bus.llc_mem_req_hprot  = 2'($urandom_range(0, 3));
    wait_ready();
    @(negedge clk);
    exp_wr++;
    bus.llc_mem_req_valid  = 1'b0;
    bus.llc_mem_req_line   = '1;   // garbage while not valid
  endtask

  task automatic do_read(input logic [LINE_ADDR_BITS-1:0] addr,
                         output logic [BITS_PER_LINE-1:0] line,
                         output int lat);
    bus.llc_mem_req_valid  = 1'b1;
    bus.llc_mem_req_hwrite = 1'b0;
    bus.llc_mem_req_addr   = addr;
    wait_ready();
    @(negedge clk);
    exp_rd++;
    bus.llc_mem_req_valid  = 1'b0;
    lat = 1;
    while (!bus.llc_mem_rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    line = bus.llc_mem_rsp_line;
    bus.llc_mem_rsp_ready = 1'b1;
    @(negedge clk);
    bus.llc_mem_rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [BITS_PER_LINE-1:0] line;
    logic                     saw;
    int                       lat;
    int                       n;

    vecs[0]  = '{1'b0, 26'h005,     '0};
    vecs[1]  = '{1'b1, 26'h012,     {16{8'hA5}}};
    vecs[2]  = '{1'b0, 26'h012,     {16{8'hA5}}};
    vecs[3]  = '{1'b1, 26'h003,     {8{16'h1111}}};
    vecs[4]  = '{1'b1, 26'h103,     {8{16'h2222}}};
    vecs[5]  = '{1'b0, 26'h003,     {8{16'h2222}}};
    vecs[6]  = '{1'b0, 26'h103,     {8{16'h2222}}};
    vecs[7]  = '{1'b1, 26'h0FF,     128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF};
    vecs[8]  = '{1'b0, 26'h0FF,     128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF};
    vecs[9]  = '{1'b0, 26'h000,     '0};
    vecs[10] = '{1'b1, 26'h3FFFF00, {16{8'h77}}};
    vecs[11] = '{1'b0, 26'h000,     {16{8'h77}}};

    bus.llc_mem_req_valid  = 1'b0;
    bus.llc_mem_req_hwrite = 1'b0;
    bus.llc_mem_req_hsize  = 3'd6;
    bus.llc_mem_req_hprot  = 2'd0;
    bus.llc_mem_req_addr   = '0;
    bus.llc_mem_req_line   = '0;
    bus.llc_mem_rsp_ready  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset req_ready", bus.llc_mem_req_ready, 0);
    chk("reset rsp_valid", bus.llc_mem_rsp_valid, 0);
    chk("reset rsp_line",  bus.llc_mem_rsp_line,  '0);
    rst = 1'b1;
    wait_init(n, saw);
    chk("init cycles", n, INIT_CYC);
    chk("init rsp_valid", saw, 0);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data);
      end else begin
        do_read(vecs[i].addr, line, lat);
        chk($sformatf("vec%0d line", i), line, vecs[i].data);
        chk($sformatf("vec%0d latency", i), lat, LAT + 1);
      end
    end

    // Response stall: LLC withholds rsp_ready for 10 cycles
    bus.llc_mem_req_valid  = 1'b1;
    bus.llc_mem_req_hwrite = 1'b0;
    bus.llc_mem_req_addr   = 26'h012;
    wait_ready();
    @(negedge clk);
    exp_rd++;
    bus.llc_mem_req_valid  = 1'b0;
    lat = 1;
    while (!bus.llc_mem_rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("stall latency", lat, LAT + 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d rsp_valid", i), bus.llc_mem_rsp_valid, 1);
      chk($sformatf("stall%0d rsp_line", i), bus.llc_mem_rsp_line, {16{8'hA5}});
      chk($sformatf("stall%0d req_ready", i), bus.llc_mem_req_ready, 0);
    end
    bus.llc_mem_rsp_ready = 1'b1;
    @(negedge clk);
    bus.llc_mem_rsp_ready = 1'b0;
    chk("post-stall rsp_valid", bus.llc_mem_rsp_valid, 0);
    chk("post-stall req_ready", bus.llc_mem_req_ready, 1);

    // Reset while a read is in WAIT
    do_write(26'h044, {4{32'hDEAD_BEEF}});
    bus.llc_mem_req_valid  = 1'b1;
    bus.llc_mem_req_hwrite = 1'b0;
    bus.llc_mem_req_addr   = 26'h044;
    wait_ready();
    @(negedge clk);
    bus.llc_mem_req_valid  = 1'b0;
    chk("wait req_ready", bus.llc_mem_req_ready, 0);
    chk("wait rsp_valid", bus.llc_mem_rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    bus.llc_mem_rsp_ready = 1'b1;   // would complete a stale response if any
    @(negedge clk);
    chk("midreset req_ready", bus.llc_mem_req_ready, 0);
    chk("midreset rsp_valid", bus.llc_mem_rsp_valid, 0);
    chk("midreset rsp_line",  bus.llc_mem_rsp_line,  '0);
    bus.llc_mem_rsp_ready = 1'b0;
    rst = 1'b1;
    wait_init(n, saw);
    chk("reinit cycles", n, INIT_CYC);
    chk("reinit rsp_valid", saw, 0);
    do_read(26'h044, line, lat);
    chk("rezeroed 0x044", line, '0);
    chk("rezeroed latency", lat, LAT + 1);
    do_read(26'h012, line, lat);
    chk("rezeroed 0x012", line, '0);

    // Three more writes to round out the counter check
    do_write(26'h020, {16{8'h01}});
    do_write(26'h021, {16{8'h02}});
    do_write(26'h022, {16{8'h03}});
`ifdef LLC_MEM_STATS_EN
    @(negedge clk);
    chk("wr_count", wr_count, 128'(exp_wr));
    chk("rd_count", rd_count, 128'(exp_rd));
`endif
    do_read(26'h021, line, lat);
    chk("final read 0x021", line, {16{8'h02}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
